instr_prefetch_buffer: RTL and testbench
========================================

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  taken bne, j or jr from the pipeline; fetch restarts at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address, word aligned.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address; held stable while imem_req=1 and imem_ack=0.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 id_valid  output  1  head entry available to the IF/ID register.
REQ-012 id_instr  output  32  head instruction.
REQ-013 id_pc4  output  32  head instruction address + 4.
REQ-014 id_ready  input  1  IF/ID write enable; a pop occurs when id_valid=1 and id_ready=1.
REQ-015 stall_cycles  output  16  present only when PF_PERF_CNT_EN is defined.

Function
REQ-016 The FSM has three states:
- IDLE: imem_req=0.
- REQ: imem_req=1, imem_addr=fetch_pc.
- DROP: imem_req=1, outstanding response to be discarded.
REQ-017 At most one memory request is outstanding at any time.
REQ-018 The block issues a request only when occupancy after any same-cycle pop is below DEPTH.
REQ-019 Transitions from IDLE:
- IDLE->REQ when there is space or redirect_valid=1.
REQ-020 Transitions from REQ:
- ack with space remaining -> REQ back-to-back at fetch_pc+4.
- ack with buffer full -> IDLE.
REQ-021 Transitions from REQ and DROP on redirect:
- REQ with redirect_valid=1 and imem_ack=0 -> DROP.
- In DROP, imem_addr keeps the old address until imem_ack.
REQ-022 Transitions out of DROP:
- DROP with imem_ack=1 -> REQ at the current fetch_pc; imem_rdata is discarded.
- redirect_valid=1 while in DROP updates fetch_pc and the state stays DROP.
REQ-023 On an accepted ack in REQ without redirect:
- push {imem_rdata, fetch_pc+4};
- fetch_pc <= fetch_pc+4.
REQ-024 Latency: with an empty FIFO, an ack in cycle N gives id_valid=1 with that data in cycle N+1.
REQ-025 id_instr and id_pc4 show the head entry; both are 0 when empty.
REQ-026 Simultaneous push and pop keep occupancy unchanged and preserve order.
REQ-027 Redirect has priority over everything else:
- all entries are cleared;
- fetch_pc <= redirect_pc;
- a same-cycle ack is discarded;
- a same-cycle pop is still a completed handshake.
REQ-028 Boundary cases:
- Full FIFO and id_ready=0 -> no request issued, FSM stays IDLE.
- Empty FIFO -> id_valid=0 and a pop is ignored.
REQ-029 Address arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
REQ-030 Read and write pointers are log2(DEPTH) bits and wrap naturally; occupancy is log2(DEPTH)+1 bits.

Reset
REQ-031 While reset=0, the block is asynchronously forced to:
- state IDLE; fetch_pc=RESET_PC; FIFO empty;
- imem_req=0; imem_addr=RESET_PC;
- id_valid=0; id_instr=0; id_pc4=0; stall_cycles=0.
REQ-032 The first rising edge after reset deasserts moves IDLE->REQ at RESET_PC.
REQ-033 Reset asserted during an outstanding request abandons it; a late imem_ack is ignored until the block is in REQ.

Configuration
REQ-034 When PF_PERF_CNT_EN is defined:
- port stall_cycles is present;
- it counts cycles with id_valid=1 and id_ready=0;
- it saturates at 16'hFFFF and clears only on reset.
REQ-035 When PF_PERF_CNT_EN is undefined, the port and counter are absent and all other behaviour is identical.

Verification
REQ-036 Reset release with imem_ack tied to imem_req -> fetch addresses 0, 4, 8, 12; id_pc4 sequence 4, 8, 12, 16; first id_valid on cycle 2.
REQ-037 id_ready=0 with DEPTH=4 -> exactly 4 acks are accepted, then imem_req=0; one pop -> imem_req=1 the following cycle.
REQ-038 Redirect to 32'h00000040 while the request at 8 awaits ack:
- imem_addr stays 8 until ack, and that data is dropped;
- the next request goes to 0x40; no entry from 8 reaches id_instr.
REQ-039 Redirect in the same cycle as an ack and a pop -> FIFO emptied, ack data absent, next imem_addr = redirect_pc.
REQ-040 RESET_PC=32'hFFFFFFF8 -> fetch addresses FFFFFFF8, FFFFFFFC, 00000000; id_pc4 for the entry from FFFFFFFC is 00000000.
REQ-041 With PF_PERF_CNT_EN: hold id_ready=0 for 10 cycles with a valid head -> stall_cycles=10; then assert reset=0 -> stall_cycles=0.

Source files
------------

// File: rtl/instr_prefetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_prefetch_buffer_if                                             |
// | Redirect, instruction-memory and IF/ID handshake bundle.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface instr_prefetch_buffer_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_ready;

  // master: the prefetch buffer itself
  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc4
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc4
  );
endinterface
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_prefetch_buffer                                                |
// | Single-outstanding instruction fetcher feeding a DEPTH-entry FIFO.   |
// | Optional stall counter port enabled by PF_PERF_CNT_EN.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input wire                      clk,
  input wire                      reset,
  instr_prefetch_buffer_if.master bus
`ifdef PF_PERF_CNT_EN
  ,
  output logic [15:0]             stall_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             req_q, req_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_after_pop;
  logic [31:0]      pc_plus4;
  logic             push;
  logic             pop;
  logic             ack_live;
  logic             id_valid;

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc4_mem_q   [DEPTH];

  assign id_valid = (count_q != '0);
  assign pc_plus4 = fetch_pc_q + 32'd4;

  always_comb begin
    pop             = bus.id_ready && id_valid;
    // an ack while idle belongs to a request abandoned by reset
    ack_live        = bus.imem_ack && (state_q != S_IDLE);
    count_after_pop = count_q - CNT_W'(pop);
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    addr_d          = addr_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    push            = 1'b0;

    if (bus.redirect_valid) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      if (state_q == S_IDLE || ack_live) begin
        state_d = S_REQ;
        addr_d  = bus.redirect_pc;
      end else begin
        state_d = S_DROP;
      end
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_after_pop;
      case (state_q)
        S_IDLE: begin
          if (count_after_pop < C_FULL) begin
            state_d = S_REQ;
            addr_d  = fetch_pc_q;
          end
        end
        S_REQ: begin
          if (ack_live) begin
            push       = 1'b1;
            fetch_pc_d = pc_plus4;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            count_d    = count_after_pop + CNT_W'(1);
            if (count_d < C_FULL) begin
              addr_d = pc_plus4;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (ack_live) begin
            state_d = S_REQ;
            addr_d  = fetch_pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    req_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc4_mem_q[wr_ptr_q]   <= pc_plus4;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = id_valid;
  assign bus.id_instr  = id_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign bus.id_pc4    = id_valid ? pc4_mem_q[rd_ptr_q]   : 32'd0;

`ifdef PF_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (id_valid && !bus.id_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_prefetch_buffer                                             |
// | Directed and random checks against a queue-based fetch model.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  instr_prefetch_buffer_if b0 ();
  instr_prefetch_buffer_if b1 ();

`ifdef PF_PERF_CNT_EN
  logic [15:0] stall0;
  logic [15:0] stall1;
`endif

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
`ifdef PF_PERF_CNT_EN
    , .stall_cycles (stall0)
`endif
  );

  // second instance: address wrap from a high reset PC, memory always acks
  instr_prefetch_buffer #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
`ifdef PF_PERF_CNT_EN
    , .stall_cycles (stall1)
`endif
  );

  assign b1.imem_ack       = b1.imem_req;
  assign b1.imem_rdata     = ~b1.imem_addr;
  assign b1.id_ready       = 1'b1;
  assign b1.redirect_valid = 1'b0;
  assign b1.redirect_pc    = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: outstanding/discard flags plus a queue of {instr, pc4}
  logic        m_busy;
  logic        m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  logic [15:0] m_stall;
  logic [63:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_addr  = 32'h0000_0000;
    m_pc    = 32'h0000_0000;
    m_stall = 16'd0;
    m_q.delete();
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic ack,
                            input logic [31:0] rd, input logic rdy);
    logic pop;
    pop = (m_q.size() != 0) && rdy;
    if ((m_q.size() != 0) && !rdy && (m_stall != 16'hFFFF)) m_stall++;
    if (rv) begin
      m_q.delete();
      m_pc = rpc;
      if (!m_busy || ack) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_addr = rpc;
      end else begin
        m_drop = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_busy) begin
        if (m_q.size() < DEPTH) begin
          m_busy = 1'b1;
          m_addr = m_pc;
        end
      end else if (ack) begin
        if (m_drop) begin
          m_drop = 1'b0;
          m_addr = m_pc;
        end else begin
          m_q.push_back({rd, m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
          if (m_q.size() < DEPTH) m_addr = m_pc;
          else m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 64'd0;
    check("imem_req",  {31'd0, b0.imem_req}, {31'd0, m_busy});
    check("imem_addr", b0.imem_addr, m_addr);
    check("id_valid",  {31'd0, b0.id_valid}, {31'd0, (m_q.size() != 0)});
    check("id_instr",  b0.id_instr, head[63:32]);
    check("id_pc4",    b0.id_pc4, head[31:0]);
`ifdef PF_PERF_CNT_EN
    check("stall_cycles", {16'd0, stall0}, {16'd0, m_stall});
`endif
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic ack,
                       input logic [31:0] rd, input logic rdy);
    b0.redirect_valid = rv;
    b0.redirect_pc    = rpc;
    b0.imem_ack       = ack;
    b0.imem_rdata     = rd;
    b0.id_ready       = rdy;
  endtask

  // called at a falling edge; returns at the next falling edge after checking
  task automatic step(input logic rv, input logic [31:0] rpc, input logic ack,
                      input logic [31:0] rd, input logic rdy);
    drive(rv, rpc, ack, rd, rdy);
    model_step(rv, rpc, ack, rd, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) begin
      drive(1'($urandom_range(0, 1)), 32'h0000_0080, 1'($urandom_range(0, 1)),
            $urandom(), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check_outputs();
    end
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n_acc;
    logic [31:0] r;
    logic [31:0] rpc;
    logic        ack;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);

    // sequential fetch from reset, memory acks every request
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 32'd0, m_busy, $urandom(), 1'b1);
      case (i)
        1: begin
          check("seq_addr0", b0.imem_addr, 32'h0);
          check("seq_valid0", {31'd0, b0.id_valid}, 32'd0);
          check("wrap_addr0", b1.imem_addr, 32'hFFFF_FFF8);
        end
        2: begin
          check("seq_addr4", b0.imem_addr, 32'h4);
          check("seq_pc4_4", b0.id_pc4, 32'h4);
          check("wrap_addr1", b1.imem_addr, 32'hFFFF_FFFC);
          check("wrap_pc4_1", b1.id_pc4, 32'hFFFF_FFFC);
        end
        3: begin
          check("seq_addr8", b0.imem_addr, 32'h8);
          check("seq_pc4_8", b0.id_pc4, 32'h8);
          check("wrap_addr2", b1.imem_addr, 32'h0000_0000);
          check("wrap_pc4_2", b1.id_pc4, 32'h0000_0000);
          check("wrap_instr2", b1.id_instr, 32'h0000_0003);
        end
        4: check("seq_pc4_12", b0.id_pc4, 32'hC);
        default: check("seq_pc4_16", b0.id_pc4, 32'h10);
      endcase
    end

    // fill with consumer stalled, then release one entry
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      ack = m_busy;
      if (b0.imem_req === 1'b1 && ack) n_acc++;
      step(1'b0, 32'd0, ack, $urandom(), 1'b0);
    end
    check("full_acks", n_acc, 32'd4);
    check("full_req", {31'd0, b0.imem_req}, 32'd0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("refill_req", {31'd0, b0.imem_req}, 32'd1);

    // redirect while the request at 8 is outstanding
    do_reset();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'h1111_0000, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'h1111_0004, 1'b0);
    check("drop_pre_addr", b0.imem_addr, 32'h8);
    step(1'b1, 32'h40, 1'b0, 32'd0, 1'b0);
    check("drop_hold_addr", b0.imem_addr, 32'h8);
    check("drop_flush", {31'd0, b0.id_valid}, 32'd0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("drop_hold_addr2", b0.imem_addr, 32'h8);
    step(1'b0, 32'd0, 1'b1, 32'hDEAD_0008, 1'b0);
    check("drop_new_addr", b0.imem_addr, 32'h40);
    check("drop_discard", {31'd0, b0.id_valid}, 32'd0);
    step(1'b0, 32'd0, 1'b1, 32'h2222_0040, 1'b0);
    check("drop_instr", b0.id_instr, 32'h2222_0040);
    check("drop_pc4", b0.id_pc4, 32'h44);

    // redirect coinciding with ack and pop
    do_reset();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'hAAAA_0000, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'hAAAA_0004, 1'b0);
    step(1'b1, 32'h100, 1'b1, 32'hBBBB_0008, 1'b1);
    check("rac_empty", {31'd0, b0.id_valid}, 32'd0);
    check("rac_addr", b0.imem_addr, 32'h100);
    step(1'b0, 32'd0, 1'b1, 32'h1234_5678, 1'b0);
    check("rac_instr", b0.id_instr, 32'h1234_5678);
    check("rac_pc4", b0.id_pc4, 32'h104);

`ifdef PF_PERF_CNT_EN
    do_reset();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'hCCCC_0000, 1'b0);
    repeat (10) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("perf_ten", {16'd0, stall0}, 32'd10);
    reset = 1'b0;
    #1;
    check("perf_reset", {16'd0, stall0}, 32'd0);
`endif

    // random traffic with occasional redirects and asynchronous resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r   = $urandom();
        rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (r & 32'h0000_FFFC);
        step(($urandom_range(0, 19) == 0), rpc, 1'($urandom_range(0, 1)),
             $urandom(), ($urandom_range(0, 9) < 6));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
